zoom_coef_gen: RTL and testbench

//  Walks every output pixel of one scaled frame and produces the coordinates and fraction coefficients

---
 rtl/zoom_coef_gen.sv | 143 ++++++++++++++
 tb/tb_zoom_coef_gen.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/zoom_coef_gen.sv
// Bilinear zoom coefficient generator: walks one destination frame, emits
// clamped 2x2 source coordinates and Q.4 fractions per pixel, and carries
// valid/eol/eof through a delay line that matches the interpolator latency.
module zoom_coef_gen #(
  parameter int CW  = 12,
  parameter int LAT = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [CW-1:0] src_w_i,
  input  logic [CW-1:0] src_h_i,
  input  logic [CW-1:0] dst_w_i,
  input  logic [CW-1:0] dst_h_i,
  input  logic [CW+3:0] step_x_i,
  input  logic [CW+3:0] step_y_i,
  output logic          busy_o,
  output logic          coef_valid_o,
  input  logic          coef_ready_i,
  output logic [CW-1:0] src_x0_o,
  output logic [CW-1:0] src_x1_o,
  output logic [CW-1:0] src_y0_o,
  output logic [CW-1:0] src_y1_o,
  output logic [3:0]    dx_o,
  output logic [3:0]    dy_o,
  output logic [7:0]    dx_dy_o,
  output logic          sol_o,
  output logic          eol_o,
  output logic          eof_o,
  output logic          pout_valid_o,
  output logic          pout_eol_o,
  output logic          pout_eof_o,
  output logic          done_o
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   src_w_q, src_h_q, dst_w_q, dst_h_q;
  logic [CW+3:0]   step_x_q, step_y_q;
  logic [CW+3:0]   acc_x_q, acc_y_q;
  logic [CW-1:0]   col_q, row_q;
  logic [7:0]      dx_dy_q;
  logic [LAT-1:0][2:0] pipe_q;

  logic          run, hs, eol_c, eof_c;
  logic [CW-1:0] xi, yi, wmax, hmax, x0, x1, y0, y1;
  logic          xclamp, yclamp;
  logic [3:0]    dxc, dyc;

  // Beat contents are derived from registered accumulators/counters only,
  // so they hold naturally while the downstream stalls.
  always_comb begin
    run    = (state_q == RUN);
    hs     = run & coef_ready_i;
    eol_c  = (col_q == dst_w_q - 1'b1);
    eof_c  = eol_c & (row_q == dst_h_q - 1'b1);
    xi     = acc_x_q[CW+3:4];
    yi     = acc_y_q[CW+3:4];
    wmax   = src_w_q - 1'b1;
    hmax   = src_h_q - 1'b1;
    // Once the right/bottom neighbour would fall off the image, both taps
    // collapse onto the edge pixel and the fraction is meaningless.
    xclamp = (xi >= wmax);
    yclamp = (yi >= hmax);
    x0     = xclamp ? wmax : xi;
    x1     = xclamp ? wmax : xi + 1'b1;
    y0     = yclamp ? hmax : yi;
    y1     = yclamp ? hmax : yi + 1'b1;
    dxc    = xclamp ? 4'd0 : acc_x_q[3:0];
    dyc    = yclamp ? 4'd0 : acc_y_q[3:0];
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_i) state_d = (dst_w_i != '0 && dst_h_i != '0) ? RUN : FIN;
      RUN:  if (hs && eof_c) state_d = FIN;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Frame parameters, accumulators, counters, dx*dy and the pout delay line.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      src_w_q  <= '0; src_h_q  <= '0;
      dst_w_q  <= '0; dst_h_q  <= '0;
      step_x_q <= '0; step_y_q <= '0;
      acc_x_q  <= '0; acc_y_q  <= '0;
      col_q    <= '0; row_q    <= '0;
      dx_dy_q  <= '0;
      pipe_q   <= '0;
    end else begin
      if (state_q == IDLE && start_i) begin
        src_w_q  <= src_w_i;  src_h_q  <= src_h_i;
        dst_w_q  <= dst_w_i;  dst_h_q  <= dst_h_i;
        step_x_q <= step_x_i; step_y_q <= step_y_i;
        acc_x_q  <= '0;       acc_y_q  <= '0;
        col_q    <= '0;       row_q    <= '0;
      end else if (hs) begin
        dx_dy_q <= {4'd0, dxc} * {4'd0, dyc};
        if (eol_c) begin
          acc_x_q <= '0;
          col_q   <= '0;
          acc_y_q <= acc_y_q + step_y_q;
          row_q   <= row_q + 1'b1;
        end else begin
          acc_x_q <= acc_x_q + step_x_q;
          col_q   <= col_q + 1'b1;
        end
      end
      // Free-running: the interpolator has no stall input.
      pipe_q[0] <= {hs, hs & eol_c, hs & eof_c};
      for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == FIN);
  assign coef_valid_o = run;
  assign src_x0_o     = run ? x0 : '0;
  assign src_x1_o     = run ? x1 : '0;
  assign src_y0_o     = run ? y0 : '0;
  assign src_y1_o     = run ? y1 : '0;
  assign dx_o         = run ? dxc : 4'd0;
  assign dy_o         = run ? dyc : 4'd0;
  assign sol_o        = run & (col_q == '0);
  assign eol_o        = run & eol_c;
  assign eof_o        = run & eof_c;
  assign dx_dy_o      = dx_dy_q;
  assign pout_valid_o = pipe_q[LAT-1][2];
  assign pout_eol_o   = pipe_q[LAT-1][1];
  assign pout_eof_o   = pipe_q[LAT-1][0];

endmodule

// File: tb/tb_zoom_coef_gen.sv
// Scoreboard bench for zoom_coef_gen: the driver enumerates every destination
// pixel arithmetically and queues the expected beat; a negedge monitor checks
// beats, dx_dy, pout timing, done and busy against those queues.
module tb_zoom_coef_gen;
  localparam int CW = 12, LAT = 5;

  logic clk = 0, rst = 1, start = 0, ready = 1;
  logic [CW-1:0] src_w = 0, src_h = 0, dst_w = 0, dst_h = 0;
  logic [CW+3:0] step_x = 0, step_y = 0;
  logic busy, coef_valid, sol, eol, eof, pout_valid, pout_eol, pout_eof, done;
  logic [CW-1:0] x0, x1, y0, y1;
  logic [3:0] dx, dy;
  logic [7:0] dx_dy;

  zoom_coef_gen #(.CW(CW), .LAT(LAT)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .src_w_i(src_w), .src_h_i(src_h), .dst_w_i(dst_w), .dst_h_i(dst_h),
    .step_x_i(step_x), .step_y_i(step_y),
    .busy_o(busy), .coef_valid_o(coef_valid), .coef_ready_i(ready),
    .src_x0_o(x0), .src_x1_o(x1), .src_y0_o(y0), .src_y1_o(y1),
    .dx_o(dx), .dy_o(dy), .dx_dy_o(dx_dy),
    .sol_o(sol), .eol_o(eol), .eof_o(eof),
    .pout_valid_o(pout_valid), .pout_eol_o(pout_eol), .pout_eof_o(pout_eof),
    .done_o(done)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [CW-1:0] x0, x1, y0, y1;
    logic [3:0]    dx, dy;
    logic          sol, eol, eof;
  } beat_t;
  typedef struct { int due; logic eol, eof; } pev_t;

  beat_t bq[$];
  pev_t  pq[$];
  int errors = 0, checks = 0;
  int start_k = -100, done_due = -100, nbeats = 0, rmode = 0;
  logic dxdy_pend = 0;
  logic [7:0] dxdy_exp;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // One axis of the reference: position a (Q.4) inside a source of size s.
  task automatic axis(input int a, input int s, output logic [CW-1:0] p0,
                      output logic [CW-1:0] p1, output logic [3:0] f);
    int i;
    i = a / 16;
    if (i >= s - 1) begin p0 = CW'(s - 1); p1 = CW'(s - 1); f = 0; end
    else begin p0 = CW'(i); p1 = CW'(i + 1); f = 4'(a % 16); end
  endtask

  // Start a frame; expected beats are pushed straight from pixel indices.
  task automatic run_frame(input int sw, sh, dw, dh, sx, sy);
    beat_t b;
    @(posedge clk); #1;
    src_w = CW'(sw); src_h = CW'(sh); dst_w = CW'(dw); dst_h = CW'(dh);
    step_x = 16'(sx); step_y = 16'(sy); start = 1;
    start_k = cyc;
    if (dw == 0 || dh == 0) done_due = cyc + 1;
    for (int r = 0; r < dh; r++)
      for (int c = 0; c < dw; c++) begin
        axis((c * sx) % 65536, sw, b.x0, b.x1, b.dx);
        axis((r * sy) % 65536, sh, b.y0, b.y1, b.dy);
        b.sol = (c == 0);
        b.eol = (c == dw - 1);
        b.eof = (c == dw - 1) && (r == dh - 1);
        bq.push_back(b);
      end
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk);
      if (bq.size() == 0 && !busy && cyc > start_k + 1) ok = 1;
    end
    chk("frame_timeout", ok, 1'b1);
  endtask

  // Downstream ready pattern.
  always @(posedge clk) begin
    #1;
    case (rmode)
      0: ready = 1;
      1: ready = (cyc % 3 == 0);
      default: ready = ($urandom_range(0, 9) < 6);
    endcase
  end

  // Monitor: compares against the queues; a reset cycle flushes all expectations.
  beat_t got, e;
  pev_t  pe;
  logic  exp_v, exp_p;
  always @(negedge clk) begin
    if (rst) begin
      bq.delete(); pq.delete();
      done_due  = -100;
      dxdy_pend = 0;
    end else begin
      exp_v = (bq.size() > 0) && (cyc > start_k);
      chk("coef_valid", coef_valid, exp_v);
      chk("busy", busy, exp_v || (cyc == done_due));
      chk("done", done, cyc == done_due);
      if (dxdy_pend) chk("dx_dy", dx_dy, dxdy_exp);
      dxdy_pend = 0;
      got = '{x0, x1, y0, y1, dx, dy, sol, eol, eof};
      if (coef_valid && bq.size() > 0) chk("beat", got, bq[0]);
      if (coef_valid && ready) begin
        if (bq.size() == 0) chk("extra_beat", 1'b1, 1'b0);
        else begin
          e = bq.pop_front();
          nbeats++;
          dxdy_exp  = 8'(e.dx) * 8'(e.dy);
          dxdy_pend = 1;
          pq.push_back('{cyc + LAT, e.eol, e.eof});
          if (e.eof) done_due = cyc + 1;
        end
      end
      exp_p = (pq.size() > 0) && (pq[0].due == cyc);
      chk("pout_valid", pout_valid, exp_p);
      if (exp_p) begin
        pe = pq.pop_front();
        chk("pout_flags", {pout_eol, pout_eof}, {pe.eol, pe.eof});
      end
    end
  end

  initial begin
    int nb0;
    logic hit;
    repeat (4) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", coef_valid, 0);
    chk("rst_coords", {x0, x1, y0, y1}, 0);
    chk("rst_frac", {dx, dy, dx_dy}, 0);
    chk("rst_flags", {sol, eol, eof, pout_valid, pout_eol, pout_eof, done}, 0);

    rmode = 0; run_frame(4, 4, 8, 8, 8, 8); wait_idle();
    rmode = 1; run_frame(4, 4, 8, 8, 8, 8); wait_idle();
    rmode = 0; run_frame(8, 8, 3, 3, 43, 43); wait_idle();
    rmode = 1; run_frame(2, 2, 3, 2, 24, 24); wait_idle();

    // Reset at beat 10 of a frame, then replay from the origin.
    rmode = 0;
    nb0 = nbeats;
    run_frame(4, 4, 8, 8, 8, 8);
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (nbeats - nb0 >= 10) hit = 1;
    end
    chk("beat10_timeout", hit, 1'b1);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    repeat (LAT + 2) @(negedge clk);
    run_frame(4, 4, 4, 2, 8, 8); wait_idle();

    // Empty frame, then a start while busy that must be ignored.
    run_frame(4, 4, 0, 5, 8, 8); wait_idle();
    run_frame(4, 4, 4, 4, 64, 64);
    repeat (3) @(posedge clk);
    #1; dst_w = 7; dst_h = 7; start = 1;
    @(posedge clk); #1 start = 0;
    wait_idle();

    // Randomized frames under random backpressure, including wrapping steps.
    rmode = 2;
    for (int t = 0; t < 8; t++) begin
      run_frame($urandom_range(1, 20), $urandom_range(1, 20),
                $urandom_range(1, 7), $urandom_range(1, 5),
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 64),
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 64));
      wait_idle();
    end

    repeat (LAT + 3) @(negedge clk);
    chk("pout_drain", 64'(pq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
